// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - EX-stage flag register, interrupt shadow and branch-condition resolver.
// Optional macro FLAG_BYPASS_EN: forward incoming flags on a same-cycle write/branch hazard.
module status_flag_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       c_in,
    input  logic       s_in,
    input  logic       v_in,
    input  logic       z_in,
    input  logic       flag_we,
    input  logic       ex_valid,
    input  logic       stall,
    input  logic       flush,
    input  logic       br_valid,
    input  logic [3:0] br_cond,
    input  logic       irq_save,
    input  logic       irq_restore,
    output logic [3:0] flags,
    output logic       br_taken,
    output logic       br_done,
    output logic       stall_req
);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_flags;
    logic [3:0] r_shadow;
    logic [3:0] r_cond;
    logic [3:0] w_cond_nxt;
    logic [3:0] w_in_flags;
    logic       r_br_done;
    logic       r_br_taken;
    logic       w_done_nxt;
    logic       w_taken_nxt;
    logic       w_flag_wr;
    logic       w_br_acc;

    // Flag vector layout is {C,S,V,Z}.
    function automatic logic f_eval(input logic [3:0] cond, input logic [3:0] f);
        logic c, s, v, z;
        c = f[3];
        s = f[2];
        v = f[1];
        z = f[0];
        case (cond)
            4'd0:    f_eval = 1'b1;
            4'd1:    f_eval = z;
            4'd2:    f_eval = !z;
            4'd3:    f_eval = c;
            4'd4:    f_eval = !c;
            4'd5:    f_eval = s;
            4'd6:    f_eval = !s;
            4'd7:    f_eval = v;
            4'd8:    f_eval = !v;
            4'd9:    f_eval = c & !z;
            4'd10:   f_eval = !c | z;
            4'd11:   f_eval = (s == v);
            4'd12:   f_eval = (s != v);
            4'd13:   f_eval = !z & (s == v);
            4'd14:   f_eval = z | (s != v);
            default: f_eval = 1'b0;
        endcase
    endfunction

    assign w_in_flags = {c_in, s_in, v_in, z_in};
    assign w_flag_wr  = flag_we & ex_valid & !stall & !flush;
    assign w_br_acc   = br_valid & !stall & !flush;

    always_comb begin
        w_state_nxt = r_state;
        w_cond_nxt  = r_cond;
        w_done_nxt  = 1'b0;
        w_taken_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_br_acc) begin
                    if (w_flag_wr) begin
`ifdef FLAG_BYPASS_EN
                        w_done_nxt  = 1'b1;
                        w_taken_nxt = f_eval(br_cond, w_in_flags);
`else
                        w_state_nxt = S_HOLD;
                        w_cond_nxt  = br_cond;
`endif
                    end else begin
                        w_done_nxt  = 1'b1;
                        w_taken_nxt = f_eval(br_cond, r_flags);
                    end
                end
            end
            S_HOLD: begin
                // Flags written on the hazard edge are live now; resolve on them.
                if (flush) begin
                    w_state_nxt = S_IDLE;
                end else if (!stall) begin
                    w_done_nxt  = 1'b1;
                    w_taken_nxt = f_eval(r_cond, r_flags);
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cond     <= 4'd0;
            r_br_done  <= 1'b0;
            r_br_taken <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cond     <= w_cond_nxt;
            r_br_done  <= w_done_nxt;
            r_br_taken <= w_taken_nxt;
        end
    end

    // Save always samples pre-edge flags, so save+restore together swaps them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags  <= 4'd0;
            r_shadow <= 4'd0;
        end else begin
            if (irq_save)
                r_shadow <= r_flags;
            if (irq_restore)
                r_flags <= r_shadow;
            else if (w_flag_wr)
                r_flags <= w_in_flags;
        end
    end

    assign flags    = r_flags;
    assign br_done  = r_br_done;
    assign br_taken = r_br_taken;
`ifdef FLAG_BYPASS_EN
    assign stall_req = 1'b0;
`else
    assign stall_req = (r_state == S_HOLD);
`endif

endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - directed and randomized bench for status_flag_unit against a behavioural model.
module tb_status_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       c_in, s_in, v_in, z_in;
    logic       flag_we, ex_valid, stall, flush, br_valid;
    logic [3:0] br_cond;
    logic       irq_save, irq_restore;
    logic [3:0] flags;
    logic       br_taken, br_done, stall_req;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [3:0] m_flags, m_shadow, m_pcond;
    logic       m_done, m_taken, m_pend;
    logic [3:0] exp_f;

    status_flag_unit dut (
        .clk(clk), .rst_n(rst_n),
        .c_in(c_in), .s_in(s_in), .v_in(v_in), .z_in(z_in),
        .flag_we(flag_we), .ex_valid(ex_valid), .stall(stall), .flush(flush),
        .br_valid(br_valid), .br_cond(br_cond),
        .irq_save(irq_save), .irq_restore(irq_restore),
        .flags(flags), .br_taken(br_taken), .br_done(br_done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Odd codes test a base predicate, the following even code is its complement.
    function automatic logic f_ok(input logic [3:0] cond, input logic [3:0] f);
        logic c, s, v, z, base;
        int k;
        c = f[3]; s = f[2]; v = f[1]; z = f[0];
        if (cond == 4'd0) return 1'b1;
        if (cond == 4'd15) return 1'b0;
        k = (int'(cond) + 1) / 2;
        case (k)
            1: base = z;
            2: base = c;
            3: base = s;
            4: base = v;
            5: base = c && !z;
            6: base = (s == v);
            default: base = !z && (s == v);
        endcase
        return cond[0] ? base : !base;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_flags = 4'd0; m_shadow = 4'd0; m_pcond = 4'd0;
            m_done = 1'b0; m_taken = 1'b0; m_pend = 1'b0;
        end else begin
            logic       wr, acc, nd, nt, np;
            logic [3:0] inf, nf, ns;
            inf = {c_in, s_in, v_in, z_in};
            wr  = flag_we && ex_valid && !stall && !flush;
            acc = br_valid && !stall && !flush;
            nf  = irq_restore ? m_shadow : (wr ? inf : m_flags);
            ns  = irq_save ? m_flags : m_shadow;
            nd = 1'b0; nt = 1'b0; np = m_pend;
            if (m_pend) begin
                if (flush) np = 1'b0;
                else if (!stall) begin
                    nd = 1'b1; nt = f_ok(m_pcond, m_flags); np = 1'b0;
                end
            end else if (acc) begin
                if (wr) begin
`ifdef FLAG_BYPASS_EN
                    nd = 1'b1; nt = f_ok(br_cond, inf);
`else
                    np = 1'b1; m_pcond = br_cond;
`endif
                end else begin
                    nd = 1'b1; nt = f_ok(br_cond, m_flags);
                end
            end
            m_flags = nf; m_shadow = ns; m_done = nd; m_taken = nt; m_pend = np;
        end
    end

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_flags", flags, m_flags);
            chk("model_br_done", {3'b0, br_done}, {3'b0, m_done});
            chk("model_br_taken", {3'b0, br_taken}, {3'b0, m_taken});
            chk("model_stall_req", {3'b0, stall_req}, {3'b0, m_pend});
        end
    end

    task automatic clr();
        {c_in, s_in, v_in, z_in} = 4'd0;
        flag_we = 0; ex_valid = 0; stall = 0; flush = 0;
        br_valid = 0; br_cond = 4'd0; irq_save = 0; irq_restore = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_flags(input logic [3:0] f);
        clr();
        flag_we = 1; ex_valid = 1; {c_in, s_in, v_in, z_in} = f;
        step();
        clr();
    endtask

    task automatic hazard(input logic [3:0] f, input logic [3:0] cond);
        clr();
        flag_we = 1; ex_valid = 1; {c_in, s_in, v_in, z_in} = f;
        br_valid = 1; br_cond = cond;
        step();
        clr();
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        repeat (2) step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("reset_flags", flags, 4'b0000);
        chk("reset_done", {3'b0, br_done}, 4'd0);
        chk("reset_stall_req", {3'b0, stall_req}, 4'd0);

        wr_flags(4'b0001);
        chk("write_z", flags, 4'b0001);
        br_valid = 1; br_cond = 4'd1; step(); clr();
        chk("eq_done", {3'b0, br_done}, 4'd1);
        chk("eq_taken", {3'b0, br_taken}, 4'd1);
        br_valid = 1; br_cond = 4'd2; step(); clr();
        chk("ne_done", {3'b0, br_done}, 4'd1);
        chk("ne_taken", {3'b0, br_taken}, 4'd0);

        wr_flags(4'b0000);
        hazard(4'b0100, 4'd12);
`ifdef FLAG_BYPASS_EN
        chk("byp_done", {3'b0, br_done}, 4'd1);
        chk("byp_taken", {3'b0, br_taken}, 4'd1);
        chk("byp_stall_req", {3'b0, stall_req}, 4'd0);
`else
        chk("haz_stall_req", {3'b0, stall_req}, 4'd1);
        chk("haz_done_early", {3'b0, br_done}, 4'd0);
        step();
        chk("haz_done", {3'b0, br_done}, 4'd1);
        chk("haz_taken", {3'b0, br_taken}, 4'd1);
        chk("haz_stall_clear", {3'b0, stall_req}, 4'd0);
`endif

        wr_flags(4'b1010);
        irq_save = 1; step(); clr();
        wr_flags(4'b0001);
        irq_restore = 1; step(); clr();
        chk("irq_restore", flags, 4'b1010);
        wr_flags(4'b0101);
        irq_save = 1; irq_restore = 1; step(); clr();
        chk("irq_swap_flags", flags, 4'b1010);
        irq_restore = 1; step(); clr();
        chk("irq_swap_shadow", flags, 4'b0101);

        flag_we = 1; ex_valid = 1; {c_in, s_in, v_in, z_in} = 4'b1111;
        br_valid = 1; br_cond = 4'd0; flush = 1;
        step(); clr();
        chk("flush_flags", flags, 4'b0101);
        chk("flush_done", {3'b0, br_done}, 4'd0);
        exp_f = 4'b0101;
`ifndef FLAG_BYPASS_EN
        hazard(4'b0000, 4'd0);
        chk("hold_entered", {3'b0, stall_req}, 4'd1);
        flush = 1; step(); clr();
        chk("hold_flush_stall", {3'b0, stall_req}, 4'd0);
        chk("hold_flush_done", {3'b0, br_done}, 4'd0);
        step();
        chk("hold_flush_after", {3'b0, br_done}, 4'd0);
        exp_f = 4'b0000;
`endif

        flag_we = 1; ex_valid = 1; {c_in, s_in, v_in, z_in} = 4'b1111;
        br_valid = 1; br_cond = 4'd0; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_done", {3'b0, br_done}, 4'd0);
            chk("stall_flags", flags, exp_f);
        end
        stall = 0; flag_we = 0;
        step(); clr();
        chk("stall_release_done", {3'b0, br_done}, 4'd1);
        chk("stall_release_taken", {3'b0, br_taken}, 4'd1);
        step();
        chk("stall_single_pulse", {3'b0, br_done}, 4'd0);

        hazard(4'b1111, 4'd1);
`ifndef FLAG_BYPASS_EN
        chk("rst_hold_entered", {3'b0, stall_req}, 4'd1);
`endif
        rst_n = 1'b0;
        #1;
        chk("rst_async_flags", flags, 4'b0000);
        chk("rst_async_stall", {3'b0, stall_req}, 4'd0);
        chk("rst_async_done", {3'b0, br_done}, 4'd0);
        chk("rst_async_taken", {3'b0, br_taken}, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        chk("rst_release_done", {3'b0, br_done}, 4'd0);
        chk("rst_release_stall", {3'b0, stall_req}, 4'd0);

        for (int i = 0; i < 3000; i++) begin
            {c_in, s_in, v_in, z_in} = 4'($urandom_range(15));
            flag_we     = ($urandom_range(1) == 0);
            ex_valid    = ($urandom_range(3) != 0);
            stall       = ($urandom_range(4) == 0);
            flush       = ($urandom_range(9) == 0);
            br_valid    = ($urandom_range(1) == 0);
            br_cond     = 4'($urandom_range(15));
            irq_save    = ($urandom_range(9) == 0);
            irq_restore = ($urandom_range(9) == 0);
            rst_n       = ($urandom_range(199) != 0);
            step();
        end
        rst_n = 1'b1;
        clr();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
